// File: rtl/game_turn_ctrl_if.sv
// Game-flow bus between the turn controller and its surroundings (mouse, link, display).
// The slave modport is the controller's view; master is the environment driving it.
interface game_turn_ctrl_if;
   logic       start_btn;
   logic [7:0] player_cor;
   logic [7:0] enemy_cor;
   logic       place_valid;
   logic [7:0] place_cor;
   logic       shot_valid;
   logic [7:0] shot_cor;
   logic       shot_ready;
   logic       result_valid;
   logic       result_hit;
   logic       eshot_valid;
   logic [7:0] eshot_cor;
   logic       ehit_valid;
   logic       ehit;
   logic [2:0] state;

   modport slave (
      input  start_btn, player_cor, enemy_cor, shot_ready, result_valid, result_hit,
             eshot_valid, eshot_cor,
      output place_valid, place_cor, shot_valid, shot_cor, ehit_valid, ehit, state
   );

   modport master (
      output start_btn, player_cor, enemy_cor, shot_ready, result_valid, result_hit,
             eshot_valid, eshot_cor,
      input  place_valid, place_cor, shot_valid, shot_cor, ehit_valid, ehit, state
   );
endinterface

// File: rtl/game_turn_ctrl.sv
// Turn-based game-flow FSM: ship placement, shot handshake with the link, enemy shot
// resolution against the own-ship bitmap, and win/lose detection. All outputs registered.
module game_turn_ctrl #(
   parameter int unsigned SHIP_CELLS = 10,
   parameter bit          FIRST_MOVE = 1'b1
) (
   input logic              clk,
   input logic              rst,
   game_turn_ctrl_if.slave  bus
);

   localparam int unsigned CW    = 8;
   localparam int unsigned CELLS = 256;
   localparam logic [7:0]  NONE  = 8'hFF;
   localparam logic [CW-1:0] TARGET = CW'(SHIP_CELLS);

   typedef enum logic [2:0] {
      SETUP      = 3'd0,
      READY      = 3'd1,
      AIM        = 3'd2,
      SEND       = 3'd3,
      WAIT_RES   = 3'd4,
      WAIT_ENEMY = 3'd5,
      WIN        = 3'd6,
      LOSE       = 3'd7
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        player_cor_q, enemy_cor_q;
   logic              start_btn_q;
   logic [CELLS-1:0]  own_q, own_d;
   logic [CELLS-1:0]  fired_q, fired_d;
   logic [CW-1:0]     placed_q, placed_d;
   logic [CW-1:0]     hits_q, hits_d;
   logic [CW-1:0]     losses_q, losses_d;
   logic              place_valid_q, place_valid_d;
   logic [7:0]        place_cor_q, place_cor_d;
   logic              shot_valid_q, shot_valid_d;
   logic [7:0]        shot_cor_q, shot_cor_d;
   logic              ehit_valid_q, ehit_valid_d;
   logic              ehit_q, ehit_d;

   // Press-edge detection: a held or dragged coordinate produces only one event.
   logic player_evt_c, enemy_evt_c, start_evt_c;
   assign player_evt_c = (bus.player_cor != NONE) && (player_cor_q == NONE);
   assign enemy_evt_c  = (bus.enemy_cor  != NONE) && (enemy_cor_q  == NONE);
   assign start_evt_c  = bus.start_btn & ~start_btn_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= SETUP;
         player_cor_q  <= NONE;
         enemy_cor_q   <= NONE;
         start_btn_q   <= 1'b0;
         own_q         <= '0;
         fired_q       <= '0;
         placed_q      <= '0;
         hits_q        <= '0;
         losses_q      <= '0;
         place_valid_q <= 1'b0;
         place_cor_q   <= NONE;
         shot_valid_q  <= 1'b0;
         shot_cor_q    <= NONE;
         ehit_valid_q  <= 1'b0;
         ehit_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         player_cor_q  <= bus.player_cor;
         enemy_cor_q   <= bus.enemy_cor;
         start_btn_q   <= bus.start_btn;
         own_q         <= own_d;
         fired_q       <= fired_d;
         placed_q      <= placed_d;
         hits_q        <= hits_d;
         losses_q      <= losses_d;
         place_valid_q <= place_valid_d;
         place_cor_q   <= place_cor_d;
         shot_valid_q  <= shot_valid_d;
         shot_cor_q    <= shot_cor_d;
         ehit_valid_q  <= ehit_valid_d;
         ehit_q        <= ehit_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      own_d         = own_q;
      fired_d       = fired_q;
      placed_d      = placed_q;
      hits_d        = hits_q;
      losses_d      = losses_q;
      place_valid_d = 1'b0;
      place_cor_d   = place_cor_q;
      shot_valid_d  = shot_valid_q;
      shot_cor_d    = shot_cor_q;
      ehit_valid_d  = 1'b0;
      ehit_d        = ehit_q;

      unique case (state_q)
         SETUP: begin
            if (player_evt_c && !own_q[bus.player_cor]) begin
               own_d[bus.player_cor] = 1'b1;
               placed_d              = placed_q + CW'(1);
               place_valid_d         = 1'b1;
               place_cor_d           = bus.player_cor;
               if (placed_d == TARGET) state_d = READY;
            end
         end
         READY: begin
            if (start_evt_c) state_d = FIRST_MOVE ? AIM : WAIT_ENEMY;
         end
         AIM: begin
            if (enemy_evt_c && !fired_q[bus.enemy_cor]) begin
               fired_d[bus.enemy_cor] = 1'b1;
               shot_cor_d             = bus.enemy_cor;
               shot_valid_d           = 1'b1;
               state_d                = SEND;
            end
         end
         SEND: begin
            if (shot_valid_q && bus.shot_ready) begin
               shot_valid_d = 1'b0;
               state_d      = WAIT_RES;
            end
         end
         WAIT_RES: begin
            if (bus.result_valid) begin
               if (bus.result_hit) begin
                  hits_d  = hits_q + CW'(1);
                  state_d = (hits_d == TARGET) ? WIN : AIM;
               end else begin
                  state_d = WAIT_ENEMY;
               end
            end
         end
         WAIT_ENEMY: begin
            if (bus.eshot_valid) begin
               ehit_valid_d = 1'b1;
               ehit_d       = own_q[bus.eshot_cor];
               // A hit sinks that cell so a repeated shot there reads as a miss.
               if (own_q[bus.eshot_cor]) begin
                  own_d[bus.eshot_cor] = 1'b0;
                  losses_d             = losses_q + CW'(1);
                  if (losses_d == TARGET) state_d = LOSE;
               end else begin
                  state_d = AIM;
               end
            end
         end
         WIN, LOSE: begin
            if (start_evt_c) begin
               state_d     = SETUP;
               own_d       = '0;
               fired_d     = '0;
               placed_d    = '0;
               hits_d      = '0;
               losses_d    = '0;
               place_cor_d = NONE;
               shot_cor_d  = NONE;
            end
         end
         default: state_d = SETUP;
      endcase
   end

   assign bus.state       = state_q;
   assign bus.place_valid = place_valid_q;
   assign bus.place_cor   = place_cor_q;
   assign bus.shot_valid  = shot_valid_q;
   assign bus.shot_cor    = shot_cor_q;
   assign bus.ehit_valid  = ehit_valid_q;
   assign bus.ehit        = ehit_q;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Directed bench for game_turn_ctrl with SHIP_CELLS=2, FIRST_MOVE=1.
module tb_game_turn_ctrl;

   localparam logic [7:0] S_SETUP = 8'd0, S_READY = 8'd1, S_AIM = 8'd2, S_SEND = 8'd3,
                          S_WRES = 8'd4, S_WEN = 8'd5, S_WIN = 8'd6, S_LOSE = 8'd7;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   game_turn_ctrl_if bus ();

   game_turn_ctrl #(.SHIP_CELLS(2), .FIRST_MOVE(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.start_btn    = 1'b0;
      bus.player_cor   = 8'hFF;
      bus.enemy_cor    = 8'hFF;
      bus.shot_ready   = 1'b0;
      bus.result_valid = 1'b0;
      bus.result_hit   = 1'b0;
      bus.eshot_valid  = 1'b0;
      bus.eshot_cor    = 8'h00;
   endtask

   // Player click: press for one cycle, then release for one cycle.
   task automatic pclick(input logic [7:0] c, input string tag, input logic [7:0] exp_pv,
                         input logic [7:0] exp_st);
      bus.player_cor = c;
      tick();
      chk({tag, "_pv"}, 8'(bus.place_valid), exp_pv);
      chk({tag, "_st"}, 8'(bus.state), exp_st);
      bus.player_cor = 8'hFF;
      tick();
   endtask

   task automatic press_start(input string tag, input logic [7:0] exp_st);
      bus.start_btn = 1'b1;
      tick();
      chk(tag, 8'(bus.state), exp_st);
      bus.start_btn = 1'b0;
      tick();
   endtask

   // Enemy-board click in AIM followed by immediate link acceptance.
   task automatic shoot(input logic [7:0] c, input string tag);
      bus.enemy_cor = c;
      tick();
      chk({tag, "_sv"}, 8'(bus.shot_valid), 8'd1);
      chk({tag, "_cor"}, bus.shot_cor, c);
      bus.enemy_cor  = 8'hFF;
      bus.shot_ready = 1'b1;
      tick();
      chk({tag, "_acc"}, 8'(bus.state), S_WRES);
      bus.shot_ready = 1'b0;
   endtask

   task automatic result(input logic hit, input string tag, input logic [7:0] exp_st);
      bus.result_valid = 1'b1;
      bus.result_hit   = hit;
      tick();
      chk(tag, 8'(bus.state), exp_st);
      bus.result_valid = 1'b0;
      bus.result_hit   = 1'b0;
   endtask

   task automatic eshot(input logic [7:0] c, input string tag, input logic [7:0] exp_hit,
                        input logic [7:0] exp_st);
      bus.eshot_valid = 1'b1;
      bus.eshot_cor   = c;
      tick();
      chk({tag, "_ev"}, 8'(bus.ehit_valid), 8'd1);
      chk({tag, "_eh"}, 8'(bus.ehit), exp_hit);
      chk({tag, "_st"}, 8'(bus.state), exp_st);
      bus.eshot_valid = 1'b0;
      tick();
      chk({tag, "_evoff"}, 8'(bus.ehit_valid), 8'd0);
   endtask

   initial begin
      int pulses;
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_state", 8'(bus.state), S_SETUP);
      chk("rst_pv", 8'(bus.place_valid), 8'd0);
      chk("rst_pcor", bus.place_cor, 8'hFF);
      chk("rst_sv", 8'(bus.shot_valid), 8'd0);
      chk("rst_scor", bus.shot_cor, 8'hFF);
      chk("rst_ev", 8'(bus.ehit_valid), 8'd0);
      chk("rst_eh", 8'(bus.ehit), 8'd0);

      // Held coordinate yields exactly one placement.
      bus.player_cor = 8'h23;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.place_valid === 1'b1) pulses++;
      end
      chk("hold_pulses", 8'(pulses), 8'd1);
      chk("hold_pcor", bus.place_cor, 8'h23);
      bus.player_cor = 8'hFF;
      tick();
      pclick(8'h23, "dup23", 8'd0, S_SETUP);
      chk("dup23_pcor", bus.place_cor, 8'h23);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_pcor", bus.place_cor, 8'hFF);

      pclick(8'h11, "pl11", 8'd1, S_SETUP);
      chk("pl11_cor", bus.place_cor, 8'h11);
      pclick(8'h22, "pl22", 8'd1, S_READY);
      chk("pl22_cor", bus.place_cor, 8'h22);
      press_start("start_aim", S_AIM);

      // Enemy shot outside WAIT_ENEMY is ignored.
      bus.eshot_valid = 1'b1;
      bus.eshot_cor   = 8'h11;
      tick();
      chk("aim_eshot_ev", 8'(bus.ehit_valid), 8'd0);
      chk("aim_eshot_st", 8'(bus.state), S_AIM);
      bus.eshot_valid = 1'b0;

      // Shot held while the link is not ready.
      bus.enemy_cor = 8'h45;
      tick();
      bus.enemy_cor = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_sv", 8'(bus.shot_valid), 8'd1);
         chk("hold_scor", bus.shot_cor, 8'h45);
         chk("hold_st", 8'(bus.state), S_SEND);
      end
      bus.shot_ready = 1'b1;
      tick();
      chk("acc_sv", 8'(bus.shot_valid), 8'd0);
      chk("acc_st", 8'(bus.state), S_WRES);
      bus.shot_ready = 1'b0;

      result(1'b0, "miss", S_WEN);
      eshot(8'h11, "e11a", 8'd1, S_WEN);
      eshot(8'h11, "e11b", 8'd0, S_AIM);

      // Repeat target is ignored.
      bus.enemy_cor = 8'h45;
      tick();
      chk("rep45_sv", 8'(bus.shot_valid), 8'd0);
      chk("rep45_st", 8'(bus.state), S_AIM);
      bus.enemy_cor = 8'hFF;
      tick();

      shoot(8'h46, "s46");
      result(1'b1, "hit1", S_AIM);
      shoot(8'h47, "s47");
      result(1'b1, "hit2", S_WIN);

      bus.start_btn = 1'b1;
      tick();
      chk("restart_st", 8'(bus.state), S_SETUP);
      chk("restart_scor", bus.shot_cor, 8'hFF);
      chk("restart_pcor", bus.place_cor, 8'hFF);
      bus.start_btn = 1'b0;
      tick();
      pclick(8'h11, "re11", 8'd1, S_SETUP);
      pclick(8'h22, "re22", 8'd1, S_READY);
      press_start("start2", S_AIM);

      // Reset while a shot is outstanding.
      bus.enemy_cor = 8'h50;
      tick();
      chk("pre_rst_sv", 8'(bus.shot_valid), 8'd1);
      bus.enemy_cor = 8'hFF;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("send_rst_sv", 8'(bus.shot_valid), 8'd0);
      chk("send_rst_st", 8'(bus.state), S_SETUP);

      // Lose path: both own cells are hit.
      pclick(8'h11, "l11", 8'd1, S_SETUP);
      pclick(8'h22, "l22", 8'd1, S_READY);
      press_start("start3", S_AIM);
      shoot(8'h60, "s60");
      result(1'b0, "miss2", S_WEN);
      eshot(8'h11, "le11", 8'd1, S_WEN);
      eshot(8'h22, "le22", 8'd1, S_LOSE);

      // Result pulse outside WAIT_RES leaves state alone.
      result(1'b1, "lose_res", S_LOSE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
